// File: rtl/intp_sample_feeder.sv
// Feeds complex samples from a non-show-ahead FIFO to the linear interpolator as
// real/imag beat pairs, one frame of N samples per accepted cfg_start.
module intp_sample_feeder #(
    parameter int W  = 24,
    parameter int LW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_start,
    input  logic [W-1:0]  cfg_k_pos,
    input  logic [LW-1:0] cfg_num_samples,
    input  logic          fifo_empty,
    output logic          fifo_rd_en,
    input  logic [2*W-1:0] fifo_rdata,
    output logic          start_v_intp,
    output logic [W-1:0]  k_pos,
    output logic          op_from_fifo_vld,
    output logic          is_real,
    output logic [W-1:0]  op_from_fifo,
    output logic          busy,
    output logic          frame_done,
    output logic          cfg_err
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RD,
        CAP,
        IMAG,
        DRAIN
    } state_t;

    // Clears the position sign bit while still consuming every input bit.
    localparam logic [W-1:0] K_MASK = {1'b0, {(W-1){1'b1}}};

    state_t        state_reg;
    logic [LW-1:0] cnt_reg;
    logic [1:0]    drain_reg;
    logic [W-1:0]  k_pos_reg;
    logic          rd_en_reg;
    logic          start_reg;
    logic          busy_reg;
    logic          done_reg;
    logic          err_reg;

    logic          data_vld_reg;
    logic          imag_pend_reg;
    logic [W-1:0]  imag_hold_reg;
    logic          vld_reg;
    logic          is_real_reg;
    logic [W-1:0]  op_reg;

    // Control FSM. CAP is the cycle the pop is on the FIFO port; IMAG is the cycle
    // its data lands, which is also the earliest point the next pop may be issued
    // so that pops stay two cycles apart and beats stay back to back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            drain_reg <= '0;
            k_pos_reg <= '0;
            rd_en_reg <= 1'b0;
            start_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            rd_en_reg <= 1'b0;
            start_reg <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cfg_start) begin
                        if (cfg_num_samples >= LW'(2)) begin
                            k_pos_reg <= cfg_k_pos & K_MASK;
                            cnt_reg   <= cfg_num_samples;
                            start_reg <= 1'b1;
                            busy_reg  <= 1'b1;
                            state_reg <= INIT;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                INIT: begin
                    state_reg <= RD;
                end
                RD: begin
                    if (!fifo_empty && (cnt_reg != '0)) begin
                        rd_en_reg <= 1'b1;
                        cnt_reg   <= cnt_reg - LW'(1);
                        state_reg <= CAP;
                    end
                end
                CAP: begin
                    state_reg <= IMAG;
                end
                IMAG: begin
                    if (cnt_reg == '0) begin
                        drain_reg <= '0;
                        state_reg <= DRAIN;
                    end else if (!fifo_empty) begin
                        rd_en_reg <= 1'b1;
                        cnt_reg   <= cnt_reg - LW'(1);
                        state_reg <= CAP;
                    end else begin
                        state_reg <= RD;
                    end
                end
                DRAIN: begin
                    // Lines frame_done up with the interpolator's last imag result.
                    if (drain_reg == 2'd2) begin
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        drain_reg <= drain_reg + 2'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Beat serialiser: real half goes out the cycle after data lands, imag half
    // from the hold register on the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_vld_reg  <= 1'b0;
            imag_pend_reg <= 1'b0;
            imag_hold_reg <= '0;
            vld_reg       <= 1'b0;
            is_real_reg   <= 1'b0;
            op_reg        <= '0;
        end else begin
            data_vld_reg <= rd_en_reg;
            if (data_vld_reg) begin
                vld_reg       <= 1'b1;
                is_real_reg   <= 1'b1;
                op_reg        <= fifo_rdata[2*W-1:W];
                imag_hold_reg <= fifo_rdata[W-1:0];
                imag_pend_reg <= 1'b1;
            end else if (imag_pend_reg) begin
                vld_reg       <= 1'b1;
                is_real_reg   <= 1'b0;
                op_reg        <= imag_hold_reg;
                imag_pend_reg <= 1'b0;
            end else begin
                vld_reg     <= 1'b0;
                is_real_reg <= 1'b0;
            end
        end
    end

    assign fifo_rd_en       = rd_en_reg;
    assign start_v_intp     = start_reg;
    assign k_pos            = k_pos_reg;
    assign op_from_fifo_vld = vld_reg;
    assign is_real          = is_real_reg;
    assign op_from_fifo     = op_reg;
    assign busy             = busy_reg;
    assign frame_done       = done_reg;
    assign cfg_err          = err_reg;

endmodule

// File: tb/tb_intp_sample_feeder.sv
// Scoreboard bench for intp_sample_feeder: a FIFO model feeds samples, expected
// beats are queued at stimulus time and popped by an independent monitor.
module tb_intp_sample_feeder;
    localparam int W  = 24;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_start = 1'b0;
    logic [W-1:0]  cfg_k_pos = '0;
    logic [LW-1:0] cfg_num_samples = '0;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [2*W-1:0] fifo_rdata = '0;
    logic          start_v_intp;
    logic [W-1:0]  k_pos;
    logic          op_from_fifo_vld;
    logic          is_real;
    logic [W-1:0]  op_from_fifo;
    logic          busy;
    logic          frame_done;
    logic          cfg_err;

    always #5 clk = ~clk;

    intp_sample_feeder #(.W(W), .LW(LW)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_k_pos(cfg_k_pos),
        .cfg_num_samples(cfg_num_samples), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .fifo_rdata(fifo_rdata), .start_v_intp(start_v_intp),
        .k_pos(k_pos), .op_from_fifo_vld(op_from_fifo_vld), .is_real(is_real),
        .op_from_fifo(op_from_fifo), .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
    );

    // FIFO model: data appears the cycle after a pop; flushed while in reset.
    logic [2*W-1:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (!rst_n) rd_ptr <= wr_ptr;
        else if (fifo_rd_en && (wr_ptr != rd_ptr)) begin
            fifo_rdata <= mem[rd_ptr];
            rd_ptr     <= rd_ptr + 1;
        end
    end

    typedef struct packed { logic is_r; logic [W-1:0] d; } beat_t;
    beat_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int beat_total = 0;
    int beat_cyc [0:63];
    int rd_total = 0;
    int start_cnt = 0;
    int start_cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int busy_seen = 0;
    int last_imag_cyc = 0;
    logic prev_start = 1'b0;
    logic [W-1:0] exp_k = '0;

    function automatic void check(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor
    always @(negedge clk) begin
        beat_t e;
        cyc++;
        if (op_from_fifo_vld) begin
            $display("beat %s %06h cycle %0d", is_real ? "re" : "im", op_from_fifo, cyc);
            if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("beat_kind", is_real, e.is_r);
                check("beat_data", op_from_fifo, e.d);
            end
            if (beat_total < 64) beat_cyc[beat_total] = cyc;
            beat_total++;
            if (!is_real) last_imag_cyc = cyc;
        end
        if (fifo_rd_en) begin
            check("rd_en_on_empty", fifo_empty, 0);
            rd_total++;
        end
        if (start_v_intp) begin
            check("start_single_cycle", prev_start, 0);
            start_cnt++;
            start_cyc = cyc;
        end
        prev_start = start_v_intp;
        if (frame_done) begin
            check("done_after_last_imag", cyc - last_imag_cyc, 2);
            check("busy_drops_with_done", busy, 0);
            done_cnt++;
        end
        if (busy) begin
            busy_seen++;
            check("k_pos_held", k_pos, exp_k);
        end
        if (cfg_err) err_cnt++;
    end

    task automatic step(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push_sample(logic [W-1:0] re, logic [W-1:0] im);
        mem[wr_ptr] = {re, im};
        wr_ptr++;
        exp_q.push_back({1'b1, re});
        exp_q.push_back({1'b0, im});
    endtask

    task automatic issue_start(logic [W-1:0] k, logic [LW-1:0] n);
        cfg_start = 1'b1;
        cfg_k_pos = k;
        cfg_num_samples = n;
        step(1);
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(int target);
        int i = 0;
        while (done_cnt < target && i < 300) begin step(1); i++; end
        check("frame_done_seen", done_cnt >= target, 1);
    endtask

    task automatic wait_beats(int target);
        int i = 0;
        while (beat_total < target && i < 300) begin step(1); i++; end
        check("beats_reached", beat_total >= target, 1);
    endtask

    initial begin
        int s0, d0, e0, bt, rt;
        logic [LW-1:0] bad_n [0:1];
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, d0, e0, bt, rt;
        logic [LW-1:0] bad_n [0:1];
        bad_n[0] = 16'd1;
        bad_n[1] = 16'd0;

        step(1);
        check("reset_outputs", {fifo_rd_en, start_v_intp, k_pos, op_from_fifo_vld, is_real,
                                op_from_fifo, busy, frame_done, cfg_err}, 0);
        step(2);
        rst_n = 1'b1;
        step(2);

        // Frame 1: N=3, back-to-back beats, first beat 4 cycles after start pulse
        push_sample(24'd1, 24'd2); push_sample(24'd3, 24'd4); push_sample(24'd5, 24'd6);
        exp_k = 24'h400000; beat_total = 0; s0 = start_cnt; d0 = done_cnt;
        issue_start(24'h400000, 16'd3);
        wait_done(d0 + 1);
        check("f1_start_pulses", start_cnt - s0, 1);
        check("f1_beat_count", beat_total, 6);
        check("f1_first_beat_latency", beat_cyc[0] - start_cyc, 4);
        check("f1_back_to_back", beat_cyc[5] - beat_cyc[0], 5);
        check("f1_queue_empty", exp_q.size(), 0);

        // Frame 2: sign bit of k forced to zero, held after the frame
        push_sample(24'd7, 24'd8); push_sample(24'd9, 24'd10);
        exp_k = 24'h400000; beat_total = 0; d0 = done_cnt;
        issue_start(24'hC00000, 16'd2);
        wait_done(d0 + 1);
        check("f2_k_pos_after", k_pos, 24'h400000);
        check("f2_back_to_back", beat_cyc[3] - beat_cyc[0], 3);
        check("f2_queue_empty", exp_q.size(), 0);

        // Frame 3: FIFO runs dry for 5 cycles mid-frame
        push_sample(24'h11, 24'h12); push_sample(24'h13, 24'h14);
        exp_k = 24'h000123; beat_total = 0; d0 = done_cnt;
        issue_start(24'h000123, 16'd4);
        wait_beats(4);
        bt = beat_total; rt = rd_total;
        step(5);
        check("gap_no_beats", beat_total, bt);
        check("gap_no_rd_en", rd_total, rt);
        check("gap_busy", busy, 1);
        push_sample(24'h15, 24'h16); push_sample(24'h17, 24'h18);
        wait_done(d0 + 1);
        check("f3_beat_count", beat_total, 8);
        check("f3_queue_empty", exp_q.size(), 0);

        // Rejected configurations: N=1 and N=0
        for (int i = 0; i < 2; i++) begin
            e0 = err_cnt; s0 = start_cnt; busy_seen = 0;
            issue_start(24'h0ABCDE, bad_n[i]);
            step(4);
            check("cfg_err_pulse", err_cnt - e0, 1);
            check("cfg_err_no_start", start_cnt - s0, 0);
            check("cfg_err_not_busy", busy_seen, 0);
        end

        // Frame 4: cfg_start while busy is ignored
        push_sample(24'h21, 24'h22); push_sample(24'h23, 24'h24); push_sample(24'h25, 24'h26);
        exp_k = 24'h2AAAAA; beat_total = 0; s0 = start_cnt; d0 = done_cnt; e0 = err_cnt;
        issue_start(24'h2AAAAA, 16'd3);
        step(3);
        check("f4_busy_at_poke", busy, 1);
        issue_start(24'h7FFFFF, 16'd2);
        wait_done(d0 + 1);
        check("f4_single_start", start_cnt - s0, 1);
        check("f4_beat_count", beat_total, 6);
        check("f4_k_unchanged", k_pos, 24'h2AAAAA);
        check("f4_no_err", err_cnt - e0, 0);
        check("f4_queue_empty", exp_q.size(), 0);

        // Frame 5: reset mid-frame, then a clean frame
        push_sample(24'h31, 24'h32); push_sample(24'h33, 24'h34); push_sample(24'h35, 24'h36);
        exp_k = 24'h000055; beat_total = 0;
        issue_start(24'h000055, 16'd3);
        wait_beats(2);
        check("busy_before_reset", busy, 1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_reset_outputs", {fifo_rd_en, start_v_intp, k_pos, op_from_fifo_vld, is_real,
                                      op_from_fifo, busy, frame_done, cfg_err}, 0);
        bt = beat_total; rt = rd_total;
        step(3);
        check("reset_no_beats", beat_total, bt);
        check("reset_no_rd_en", rd_total, rt);
        rst_n = 1'b1;
        step(2);
        push_sample(24'h41, 24'h42); push_sample(24'h43, 24'h44);
        exp_k = 24'h000777; beat_total = 0; s0 = start_cnt; d0 = done_cnt;
        issue_start(24'h000777, 16'd2);
        wait_done(d0 + 1);
        check("f5_start_pulses", start_cnt - s0, 1);
        check("f5_beat_count", beat_total, 4);
        check("f5_queue_empty", exp_q.size(), 0);

        step(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
